display_driver: RTL
===================

// Module: display_driver
// PURPOSE
//  Downstream display stage for the SoC outputs. Captures the 8-bit data
//  output on dval and converts it to sign + 3 BCD digits with a sequential
//  double-dabble, then drives 4 seven-segment digits (hex3..hex0). Also
//  registers the instruction pointer and shows it as 2 hex digits (hex5..hex4).
// PARAMETERS
//  SIGNED         1  1: dout is two's complement, sign on hex3; 0: unsigned 0..255, hex3 blank
//  BLANK_LEADING  1  1: blank leading zero hundreds/tens; 0: always show 3 digits
//  SEG_ACTIVE_LOW 1  1: segment on = 0 (board default); 0: invert all hex outputs
// PORTS
//  clk    in   1  50MHz system clock
//  reset  in   1  asynchronous, active-high reset
//  dout   in   8  data value from SoC
//  dval   in   1  dout valid (level, sampled every clk)
//  ip     in   8  instruction pointer
//  busy   out  1  conversion in progress (state != IDLE)
//  hex0   out  7  ones digit, {g,f,e,d,c,b,a}
//  hex1   out  7  tens digit
//  hex2   out  7  hundreds digit
//  hex3   out  7  sign digit (minus or blank)
//  hex4   out  7  ip[3:0] in hex
//  hex5   out  7  ip[7:4] in hex
// BEHAVIOUR
//  Reset: all hex outputs blank (7'h7F active-low), busy=0, state IDLE, pend=0.
//  Reset mid-conversion aborts it; the last displayed value is not restored.
//  FSM: IDLE -> CONV (8 cycles, cnt 0..7) -> COMMIT -> IDLE or CONV.
//  Edge N, IDLE & dval: sign <= SIGNED & dout[7]; mag <= |dout| (-128 -> 128,
//   9-bit mag); bcd <= 0; cnt <= 0; -> CONV.
//  CONV: per edge, add 3 to each BCD nibble >= 5, then shift {bcd,mag} left 1.
//   cnt==7 -> COMMIT. Edges N+1..N+8.
//  COMMIT (edge N+9): hex0..hex3 update together; no partial digits are ever shown.
//   Latency: sampling edge to new display = 9 clocks; busy high N+1..N+9.
//  dval while busy: pend_val <= dout, pend <= 1; a later dval overwrites it
//   (latest wins). At COMMIT: if dval, load dout (pend cleared); else if pend,
//   load pend_val, clear pend -> CONV; else -> IDLE.
//  Blanking (BLANK_LEADING=1): hundreds blank if 0; tens blank if hundreds==0
//   and tens==0; ones always shown. hex3 = minus (7'b0111111) if sign, else blank.
//  ip path: ip registered every clk; hex5/hex4 = hex decode of that register,
//   1-clock latency, independent of FSM and busy.
// STRUCTURE
//  display_defs.vh: SEG_BLANK, SEG_MINUS, state encodings, digit seg constants.
//  Sub-module seg7_encoder (4-bit nibble -> 7-bit segments, 0-F, combinational),
//   instantiated 5x (3 BCD + 2 ip); blanking/minus muxed after it.
//  Polarity inversion applied once at the output registers.
// TESTING
//  Assert reset mid-CONV -> same cycle all hex=7'h7F, busy=0; release -> stays blank.
//  dout=8'd123, dval 1 cycle -> busy 9 clk; hex3=7F, hex2=1111001, hex1=0100100, hex0=0110000.
//  dout=8'h80 (SIGNED=1) -> hex3=0111111, hex2=1111001, hex1=0100100, hex0=0000000 (-128).
//  dout=8'd5 -> hex2=hex1=7F, hex0=0010010; with BLANK_LEADING=0 hex2=hex1=1000000.
//  dval 10, then 20 and 30 during busy -> shows 10, then 30; 20 never displayed.
//  ip=8'hA7 -> next clk hex5=0001000, hex4=1111000, regardless of busy.

Source files
------------

// File: rtl/display_driver_pkg.sv
// Shared types and constants for the display driver: FSM states, segment patterns,
// and the double-dabble nibble correction.
package display_driver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_e;

  // Segment patterns are active-low internally, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SegBlank = 7'h7F;
  localparam logic [6:0] SegMinus = 7'b0111111;

  localparam logic [2:0] LastStep = 3'd7;

  function automatic logic [3:0] dd_adjust(logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/display_driver_seg7_encoder.sv
// Combinational hex nibble to seven-segment decoder, active-low, {g,f,e,d,c,b,a}.
module seg7_encoder
  import display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/display_driver.sv
// Captures dout on dval, converts to sign + 3 BCD digits with a sequential double-dabble,
// and drives six seven-segment displays (value on hex3..hex0, registered ip on hex5..hex4).
module display_driver
  import display_driver_pkg::*;
#(
  parameter bit SIGNED         = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dout,
  input  logic       dval,
  input  logic [7:0] ip,
  output logic       busy,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5
);

  localparam logic [6:0] Pol = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        sign_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic        pend_q;
  logic [7:0]  pend_val_q;

  logic        load;
  logic [7:0]  load_val;
  logic        load_neg;
  logic [11:0] bcd_next;

  logic [6:0]  seg_ones, seg_tens, seg_hund, seg_ip_lo, seg_ip_hi;
  logic [6:0]  disp_ones, disp_tens, disp_hund, disp_sign;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (dval) state_d = StConv;
      StConv:   if (cnt_q == LastStep) state_d = StCommit;
      StCommit: state_d = (dval || pend_q) ? StConv : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != StIdle);
    load     = ((state_q == StIdle) && dval) || ((state_q == StCommit) && (dval || pend_q));
    load_val = dval ? dout : pend_val_q;
    load_neg = SIGNED && load_val[7];
  end

  // Hundreds never exceeds 2 for an 8-bit magnitude, so it needs no +3 correction.
  assign bcd_next = {bcd_q[10:8], dd_adjust(bcd_q[7:4]), dd_adjust(bcd_q[3:0]), mag_q[7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      sign_q <= load_neg;
      // -128 negates to 8'h80, which reads correctly as unsigned 128
      mag_q  <= load_neg ? (~load_val + 8'd1) : load_val;
      bcd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      if (busy && dval) begin
        pend_q     <= 1'b1;
        pend_val_q <= dout;
      end
      if (state_q == StConv) begin
        cnt_q <= cnt_q + 3'd1;
        bcd_q <= bcd_next;
        mag_q <= {mag_q[6:0], 1'b0};
      end
    end
  end

  seg7_encoder u_seg_ones  (.nibble(bcd_q[3:0]),  .seg(seg_ones));
  seg7_encoder u_seg_tens  (.nibble(bcd_q[7:4]),  .seg(seg_tens));
  seg7_encoder u_seg_hund  (.nibble(bcd_q[11:8]), .seg(seg_hund));
  seg7_encoder u_seg_ip_lo (.nibble(ip[3:0]),     .seg(seg_ip_lo));
  seg7_encoder u_seg_ip_hi (.nibble(ip[7:4]),     .seg(seg_ip_hi));

  always_comb begin
    disp_ones = seg_ones;
    disp_tens = (BLANK_LEADING && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ?
                SegBlank : seg_tens;
    disp_hund = (BLANK_LEADING && (bcd_q[11:8] == 4'd0)) ? SegBlank : seg_hund;
    disp_sign = sign_q ? SegMinus : SegBlank;
  end

  // Value digits change only in COMMIT so a half-converted number is never visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex0 <= SegBlank ^ Pol;
      hex1 <= SegBlank ^ Pol;
      hex2 <= SegBlank ^ Pol;
      hex3 <= SegBlank ^ Pol;
      hex4 <= SegBlank ^ Pol;
      hex5 <= SegBlank ^ Pol;
    end else begin
      hex4 <= seg_ip_lo ^ Pol;
      hex5 <= seg_ip_hi ^ Pol;
      if (state_q == StCommit) begin
        hex0 <= disp_ones ^ Pol;
        hex1 <= disp_tens ^ Pol;
        hex2 <= disp_hund ^ Pol;
        hex3 <= disp_sign ^ Pol;
      end
    end
  end

endmodule
